// File: rtl/agh_stream_pkg.sv
// agh_stream_pkg: shared types and width helpers for the stream output buffer.
//   beat_t       - packed Avalon-ST beat {sop, eop, data} at the default sample width
//   pkt_state_t  - framing tracker state (outside / inside a packet)
//   credit_w()   - width of the in-flight credit counter (holds 0..latency+1)
//   level_w()    - width of a FIFO occupancy count (holds 0..depth)
package agh_stream_pkg;

  localparam int unsigned BEAT_DATA_W = 16;

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_OPEN = 1'b1
  } pkt_state_t;

  function automatic int unsigned credit_w(input int unsigned latency);
    return $clog2(latency + 2);
  endfunction

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_beat_fifo.sv
// stream_beat_fifo: first-word-fall-through beat storage.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (clears pointers and count)
//   push        - write push_data this cycle (ignored when full unless popping)
//   push_data   - beat to store
//   pop         - consume the head entry (ignored when empty)
//   head_data   - current head entry, valid whenever empty=0
//   count       - stored entry count, 0..DEPTH
//   full, empty - occupancy flags
module stream_beat_fifo
  import agh_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = level_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A pop frees the slot in the same edge, so a push is legal even when full.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_output_buffer.sv
// stream_output_buffer: Avalon-ST source end of the DSP datapath.
// Buffers beats leaving a fixed-latency DSP pipeline and issues upstream ready as
// credit so that beats already in the pipeline always have a FIFO slot waiting.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sink_valid      - upstream valid at pipeline entry (observed for credit only)
//   sink_ready      - upstream ready, high while stored + in-flight beats < DEPTH
//   pipe_valid/data/sop/eop - beat leaving the DSP pipeline
//   source_valid/data/sop/eop, source_ready - Avalon-ST source (FWFT from FIFO)
//   fill_level      - stored beat count
//   overflow        - sticky: a pipeline beat was dropped on a full FIFO
//   framing_err     - sticky: sop/eop sequence violation on a stored beat
module stream_output_buffer
  import agh_stream_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic                   pipe_valid,
  input  logic [DATA_W-1:0]      pipe_data,
  input  logic                   pipe_sop,
  input  logic                   pipe_eop,
  output logic                   source_valid,
  output logic [DATA_W-1:0]      source_data,
  output logic                   source_sop,
  output logic                   source_eop,
  input  logic                   source_ready,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic                   framing_err
);

  localparam int unsigned CNT_W  = level_w(DEPTH);
  localparam int unsigned IF_W   = credit_w(LATENCY);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned BEAT_W = DATA_W + 2;
  localparam logic [IF_W-1:0] IF_MAX = IF_W'(LATENCY + 1);

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [BEAT_W-1:0] head;
  logic              pop;
  logic              push;
  logic              drop;
  logic              accept;
  logic [SUM_W-1:0]  credit_sum;
  logic [IF_W-1:0]   inflight;
  logic [IF_W-1:0]   inflight_next;
  pkt_state_t        pkt_state;
  pkt_state_t        pkt_state_next;
  logic              frame_violation;

  stream_beat_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pipe_sop, pipe_eop, pipe_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign source_valid = !empty;
  assign {source_sop, source_eop, source_data} = head;
  assign fill_level   = count;

  assign pop  = !empty && source_ready;
  assign push = pipe_valid && (!full || pop);
  assign drop = pipe_valid && full && !pop;

  // Credit counts every beat already stored or still inside the DSP pipeline,
  // so each accepted beat is guaranteed a slot when it emerges.
  assign credit_sum = {1'b0, count} + SUM_W'(inflight);
  assign sink_ready = !rst && (credit_sum < SUM_W'(DEPTH));
  assign accept     = sink_valid && sink_ready;

  always_comb begin
    inflight_next = inflight;
    if (accept && !pipe_valid && (inflight != IF_MAX)) begin
      inflight_next = inflight + IF_W'(1);
    end else if (!accept && pipe_valid && (inflight != '0)) begin
      inflight_next = inflight - IF_W'(1);
    end
  end

  // Only beats that are actually stored take part in the framing check.
  always_comb begin
    pkt_state_next  = pkt_state;
    frame_violation = 1'b0;
    if (push) begin
      if (pipe_sop) begin
        if (pkt_state == PKT_OPEN) begin
          frame_violation = 1'b1;
        end
        pkt_state_next = pipe_eop ? PKT_IDLE : PKT_OPEN;
      end else begin
        if (pkt_state == PKT_IDLE) begin
          frame_violation = 1'b1;
        end
        if (pipe_eop) begin
          pkt_state_next = PKT_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= '0;
      pkt_state   <= PKT_IDLE;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      inflight  <= inflight_next;
      pkt_state <= pkt_state_next;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (frame_violation) begin
        framing_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_output_buffer.sv
// tb_stream_output_buffer: directed bench for stream_output_buffer with a
// LATENCY-stage delay line standing in for the DSP pipeline and an injection
// override on the pipe_* inputs for beats that bypass credit.
module tb_stream_output_buffer;
  import agh_stream_pkg::*;

  localparam int unsigned LAT = 5;
  localparam int unsigned DEP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sink_valid;
  logic        sink_ready;
  logic        pipe_valid;
  logic [15:0] pipe_data;
  logic        pipe_sop;
  logic        pipe_eop;
  logic        source_valid;
  logic [15:0] source_data;
  logic        source_sop;
  logic        source_eop;
  logic        source_ready;
  logic [4:0]  fill_level;
  logic        overflow;
  logic        framing_err;

  beat_t sink_beat;
  beat_t inj_beat;
  logic  inj_en;
  logic  dl_v [LAT];
  beat_t dl_b [LAT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_output_buffer #(
    .DATA_W  (16),
    .DEPTH   (DEP),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .pipe_valid   (pipe_valid),
    .pipe_data    (pipe_data),
    .pipe_sop     (pipe_sop),
    .pipe_eop     (pipe_eop),
    .source_valid (source_valid),
    .source_data  (source_data),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_ready (source_ready),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .framing_err  (framing_err)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        dl_v[i] <= 1'b0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_v[0] <= sink_valid && sink_ready;
      dl_b[0] <= sink_beat;
      for (int unsigned i = 1; i < LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign pipe_valid = inj_en ? 1'b1 : dl_v[LAT-1];
  assign {pipe_sop, pipe_eop, pipe_data} = inj_en ? inj_beat : dl_b[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sink_valid   = 1'b0;
    inj_en       = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drives sink_valid for 40 cycles with source_ready low; beats base+n, sop on n==0.
  task automatic fill_via_sink(input logic [15:0] base, input bit last_eop,
                               output int unsigned n);
    n            = 0;
    source_ready = 1'b0;
    sink_valid   = 1'b1;
    for (int unsigned c = 0; c < 40; c++) begin
      sink_beat.data = base + 16'(n);
      sink_beat.sop  = (n == 0);
      sink_beat.eop  = last_eop && (n == 15);
      if (sink_ready) n++;
      step();
    end
    sink_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    sink_valid   = 1'b1;
    sink_beat    = '{sop: 1'b1, eop: 1'b1, data: 16'h0055};
    source_ready = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      step();
      checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL reset_source_valid: got %b expected 0", source_valid); end
      checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL reset_sink_ready: got %b expected 0", sink_ready); end
      checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill_level: got %0d expected 0", fill_level); end
    end
    rst        = 1'b0;
    sink_valid = 1'b0;
    #1;
    checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL reset_release_sink_ready: got %b expected 1", sink_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_framing_err: got %b expected 0", framing_err); end
  endtask

  task automatic test_passthrough();
    logic [15:0] exp_data [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    int unsigned seen = 0;
    logic pv;
    source_ready = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (i < 4) begin
        sink_valid     = 1'b1;
        sink_beat.data = exp_data[i];
        sink_beat.sop  = (i == 0);
        sink_beat.eop  = (i == 3);
        checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL pass_sink_ready: cycle %0d got %b expected 1", i, sink_ready); end
      end else begin
        sink_valid = 1'b0;
      end
      checks++; if (fill_level > 5'd1) begin errors++; $display("FAIL pass_fill_level: got %0d expected <=1", fill_level); end
      pv = pipe_valid;
      step();
      if (pv && seen < 4) begin
        checks++; if (source_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: beat %0d got %b expected 1", seen, source_valid); end
        checks++; if (source_data !== exp_data[seen]) begin errors++; $display("FAIL pass_data: got %h expected %h", source_data, exp_data[seen]); end
        checks++; if (source_sop !== (seen == 0)) begin errors++; $display("FAIL pass_sop: beat %0d got %b", seen, source_sop); end
        checks++; if (source_eop !== (seen == 3)) begin errors++; $display("FAIL pass_eop: beat %0d got %b", seen, source_eop); end
        seen++;
      end else begin
        checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL pass_idle_valid: cycle %0d got %b expected 0", i, source_valid); end
      end
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL pass_beat_count: got %0d expected 4", seen); end
  endtask

  task automatic test_backpressure();
    int unsigned n;
    fill_via_sink(16'h0100, 1'b1, n);
    checks++; if (n !== 16) begin errors++; $display("FAIL bp_accepts: got %0d expected 16", n); end
    checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL bp_sink_ready: got %b expected 0", sink_ready); end
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL bp_fill: got %0d expected 16", fill_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b expected 0", overflow); end
    source_ready = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      checks++; if (source_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid: beat %0d got %b", i, source_valid); end
      checks++; if (source_data !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL bp_drain_data: got %h expected %h", source_data, 16'h0100 + 16'(i)); end
      checks++; if (source_sop !== (i == 0) || source_eop !== (i == 15)) begin errors++; $display("FAIL bp_drain_flags: beat %0d got sop %b eop %b", i, source_sop, source_eop); end
      step();
    end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL bp_drained_fill: got %0d expected 0", fill_level); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL bp_framing: got %b expected 0", framing_err); end
  endtask

  task automatic test_full_push_pop();
    int unsigned n;
    fill_via_sink(16'h0200, 1'b0, n);
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL fpp_fill_before: got %0d expected 16", fill_level); end
    checks++; if (source_data !== 16'h0200) begin errors++; $display("FAIL fpp_head: got %h expected 0200", source_data); end
    source_ready = 1'b1;
    inj_beat     = '{sop: 1'b0, eop: 1'b1, data: 16'h0210};
    inj_en       = 1'b1;
    step();
    inj_en = 1'b0;
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL fpp_fill_after: got %0d expected 16", fill_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
    for (int unsigned i = 0; i < 16; i++) begin
      checks++; if (source_valid !== 1'b1 || source_data !== 16'h0201 + 16'(i)) begin errors++; $display("FAIL fpp_drain: beat %0d got valid %b data %h expected %h", i, source_valid, source_data, 16'h0201 + 16'(i)); end
      checks++; if (source_eop !== (i == 15)) begin errors++; $display("FAIL fpp_eop: beat %0d got %b", i, source_eop); end
      step();
    end
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b expected 0", source_valid); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL fpp_framing: got %b expected 0", framing_err); end
  endtask

  task automatic test_overflow();
    int unsigned n;
    fill_via_sink(16'h0300, 1'b1, n);
    inj_beat = '{sop: 1'b0, eop: 1'b0, data: 16'hDEAD};
    inj_en   = 1'b1;
    step();
    inj_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill: got %0d expected 16", fill_level); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL ovf_dropped_framing: got %b expected 0", framing_err); end
    step(); step(); step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    source_ready = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      checks++; if (source_valid !== 1'b1 || source_data !== 16'h0300 + 16'(i)) begin errors++; $display("FAIL ovf_drain: beat %0d got valid %b data %h expected %h", i, source_valid, source_data, 16'h0300 + 16'(i)); end
      step();
    end
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_injected_beat: got valid %b data %h", source_valid, source_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_after_drain: got %b expected 1", overflow); end
  endtask

  task automatic test_framing();
    source_ready = 1'b1;
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frm_overflow_cleared: got %b expected 0", overflow); end
    inj_beat = '{sop: 1'b1, eop: 1'b0, data: 16'h00A0};
    inj_en   = 1'b1;
    step();
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL frm_first_sop: got %b expected 0", framing_err); end
    inj_beat = '{sop: 1'b1, eop: 1'b0, data: 16'h00A1};
    step();
    inj_en = 1'b0;
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL frm_double_sop: got %b expected 1", framing_err); end
    checks++; if (source_data !== 16'h00A1) begin errors++; $display("FAIL frm_beat_stored: got %h expected 00a1", source_data); end

    do_reset();
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL frm_reset_clear: got %b expected 0", framing_err); end
    inj_beat = '{sop: 1'b0, eop: 1'b1, data: 16'h00B0};
    inj_en   = 1'b1;
    step();
    inj_en = 1'b0;
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL frm_orphan_eop: got %b expected 1", framing_err); end

    do_reset();
    inj_beat = '{sop: 1'b1, eop: 1'b1, data: 16'h00C0};
    inj_en   = 1'b1;
    step();
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL frm_single_beat: got %b expected 0", framing_err); end
    checks++; if (source_valid !== 1'b1 || source_data !== 16'h00C0 || source_sop !== 1'b1 || source_eop !== 1'b1) begin errors++; $display("FAIL frm_single_out: got valid %b data %h sop %b eop %b expected 1 00c0 1 1", source_valid, source_data, source_sop, source_eop); end
    inj_beat = '{sop: 1'b1, eop: 1'b1, data: 16'h00C1};
    step();
    inj_en = 1'b0;
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL frm_second_single: got %b expected 0", framing_err); end
    checks++; if (source_data !== 16'h00C1 || fill_level !== 5'd1) begin errors++; $display("FAIL frm_count1_pushpop: got data %h fill %0d expected 00c1 1", source_data, fill_level); end
  endtask

  initial begin
    rst          = 1'b1;
    sink_valid   = 1'b0;
    sink_beat    = '0;
    inj_en       = 1'b0;
    inj_beat     = '0;
    source_ready = 1'b0;
    step();
    test_reset();
    test_passthrough();
    test_backpressure();
    test_full_push_pop();
    test_overflow();
    test_framing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
